// File: rtl/sketch_update_engine.sv
// Count-min sketch storage: per-row saturating RMW increments on port A,
// CPU counter reads on port B, and a full address sweep clear after reset/request.
module sketch_update_engine #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned WIDTH    = 1024,
    parameter int unsigned IDX_BITS = 10,
    parameter int unsigned CNT_BITS = 32
) (
    input  logic                     axis_aclk,
    input  logic                     reset,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [ROWS*IDX_BITS-1:0] upd_idx,
    input  logic [ROWS-1:0]          upd_row_mask,
    input  logic                     rd_req,
    input  logic [1:0]               rd_row,
    input  logic [IDX_BITS-1:0]      rd_idx,
    output logic                     rd_ack,
    output logic [CNT_BITS-1:0]      rd_data,
    input  logic                     clear_req,
    output logic                     busy,
    output logic [15:0]              sat_events
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [IDX_BITS-1:0] clr_addr;
    logic                accept;

    logic                s1_valid;
    logic [ROWS-1:0]     s1_mask;
    logic [IDX_BITS-1:0] s1_idx    [ROWS];

    logic [CNT_BITS-1:0] mem       [ROWS][WIDTH];
    logic [CNT_BITS-1:0] a_dout    [ROWS];
    logic [CNT_BITS-1:0] b_dout    [ROWS];
    logic [IDX_BITS-1:0] a_rd_addr [ROWS];
    logic [IDX_BITS-1:0] a_wr_addr [ROWS];
    logic [CNT_BITS-1:0] a_wr_data [ROWS];
    logic [ROWS-1:0]     a_we;

    logic [ROWS-1:0]     fwd_valid;
    logic [IDX_BITS-1:0] fwd_idx   [ROWS];
    logic [CNT_BITS-1:0] fwd_val   [ROWS];

    logic [CNT_BITS-1:0] old_val   [ROWS];
    logic [CNT_BITS-1:0] new_val   [ROWS];
    logic [ROWS-1:0]     sat_hit;
    logic [ROWS-1:0]     wr_en;
    logic [16:0]         sat_sum;
    logic [15:0]         sat_next;

    logic                rd_v1;
    logic [1:0]          rd_row_q;

    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        upd_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_CLEAR: begin
                if (clr_addr == IDX_BITS'(WIDTH - 1)) state_nx = ST_RUN;
            end
            ST_RUN: begin
                upd_ready = 1'b1;
                busy      = 1'b0;
                if (clear_req) state_nx = ST_DRAIN;
            end
            ST_DRAIN: state_nx = ST_CLEAR;
            default:  state_nx = ST_CLEAR;
        endcase
    end

    assign accept = upd_valid & upd_ready;

    // S2: the last-write register per row covers a read issued on the same edge as that write
    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            a_rd_addr[r] = upd_idx[r*IDX_BITS +: IDX_BITS];
            old_val[r]   = (fwd_valid[r] && (fwd_idx[r] == s1_idx[r])) ? fwd_val[r] : a_dout[r];
            sat_hit[r]   = (old_val[r] == '1);
            new_val[r]   = sat_hit[r] ? old_val[r] : old_val[r] + CNT_BITS'(1);
            wr_en[r]     = s1_valid & s1_mask[r];
            if (state == ST_CLEAR) begin
                a_we[r]      = 1'b1;
                a_wr_addr[r] = clr_addr;
                a_wr_data[r] = '0;
            end else begin
                a_we[r]      = wr_en[r];
                a_wr_addr[r] = s1_idx[r];
                a_wr_data[r] = new_val[r];
            end
        end
    end

    always_comb begin
        sat_sum = {1'b0, sat_events};
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (wr_en[r] && sat_hit[r]) sat_sum = sat_sum + 17'd1;
        end
        sat_next = (sat_sum > 17'h0FFFF) ? 16'hFFFF : sat_sum[15:0];
    end

    // Port A carries the next token's read alongside the current token's write
    always_ff @(posedge axis_aclk) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (a_we[r]) mem[r][a_wr_addr[r]] <= a_wr_data[r];
            a_dout[r] <= mem[r][a_rd_addr[r]];
            b_dout[r] <= mem[r][rd_idx];
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (accept) begin
            s1_mask <= upd_row_mask;
            for (int unsigned r = 0; r < ROWS; r++) begin
                s1_idx[r] <= upd_idx[r*IDX_BITS +: IDX_BITS];
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            clr_addr   <= '0;
            s1_valid   <= 1'b0;
            fwd_valid  <= '0;
            sat_events <= '0;
            rd_v1      <= 1'b0;
            rd_ack     <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_addr <= clr_addr + IDX_BITS'(1);
            end else if (state == ST_DRAIN) begin
                clr_addr <= '0;
            end
            s1_valid <= accept;
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (state == ST_CLEAR) begin
                    fwd_valid[r] <= 1'b0;
                end else if (wr_en[r]) begin
                    fwd_valid[r] <= 1'b1;
                    fwd_idx[r]   <= s1_idx[r];
                    fwd_val[r]   <= new_val[r];
                end
            end
            sat_events <= (state == ST_DRAIN) ? 16'h0000 : sat_next;
            rd_v1      <= rd_req;
            rd_row_q   <= rd_row;
            rd_ack     <= rd_v1;
            if (rd_v1) rd_data <= b_dout[rd_row_q];
        end
    end

endmodule

// File: tb/tb_sketch_update_engine.sv
// Bench for sketch_update_engine: directed table reads and corner sequences on a
// full-size instance, saturation and randomized model checks on a narrow instance.
module tb_sketch_update_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic        m_upd_valid, m_upd_ready, m_rd_req, m_rd_ack, m_clear_req, m_busy;
    logic [39:0] m_upd_idx;
    logic [3:0]  m_mask;
    logic [1:0]  m_rd_row;
    logic [9:0]  m_rd_idx;
    logic [31:0] m_rd_data;
    logic [15:0] m_sat;

    logic        s_upd_valid, s_upd_ready, s_rd_req, s_rd_ack, s_clear_req, s_busy;
    logic [15:0] s_upd_idx;
    logic [3:0]  s_mask;
    logic [1:0]  s_rd_row;
    logic [3:0]  s_rd_idx;
    logic [3:0]  s_rd_data;
    logic [15:0] s_sat;

    sketch_update_engine #(.ROWS(4), .WIDTH(1024), .IDX_BITS(10), .CNT_BITS(32)) u_main (
        .axis_aclk(clk), .reset(reset), .upd_valid(m_upd_valid), .upd_ready(m_upd_ready),
        .upd_idx(m_upd_idx), .upd_row_mask(m_mask), .rd_req(m_rd_req), .rd_row(m_rd_row),
        .rd_idx(m_rd_idx), .rd_ack(m_rd_ack), .rd_data(m_rd_data), .clear_req(m_clear_req),
        .busy(m_busy), .sat_events(m_sat));

    sketch_update_engine #(.ROWS(4), .WIDTH(16), .IDX_BITS(4), .CNT_BITS(4)) u_small (
        .axis_aclk(clk), .reset(reset), .upd_valid(s_upd_valid), .upd_ready(s_upd_ready),
        .upd_idx(s_upd_idx), .upd_row_mask(s_mask), .rd_req(s_rd_req), .rd_row(s_rd_row),
        .rd_idx(s_rd_idx), .rd_ack(s_rd_ack), .rd_data(s_rd_data), .clear_req(s_clear_req),
        .busy(s_busy), .sat_events(s_sat));

    typedef struct {
        logic [1:0]  row;
        logic [9:0]  idx;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] idx;
        logic [3:0]  mask;
    } tok_t;

    typedef struct {
        int          due;
        int unsigned val;
    } rexp_t;

    rd_vec_t     tab[$];
    tok_t        ptok[$];
    rexp_t       prd[$];
    int unsigned mdl[4][16];
    int unsigned msat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic m_token(input logic [9:0] i0, input logic [9:0] i1, input logic [9:0] i2,
                           input logic [9:0] i3, input logic [3:0] mask);
        check("m_tok_ready", m_upd_ready, 1);
        m_upd_valid = 1'b1;
        m_upd_idx   = {i3, i2, i1, i0};
        m_mask      = mask;
        tick();
        m_upd_valid = 1'b0;
    endtask

    task automatic m_read(input string name, input logic [1:0] row, input logic [9:0] idx,
                          input logic [31:0] exp);
        m_rd_req = 1'b1;
        m_rd_row = row;
        m_rd_idx = idx;
        tick();
        m_rd_req = 1'b0;
        check({name, "_ack_p1"}, m_rd_ack, 0);
        tick();
        check({name, "_ack_p2"}, m_rd_ack, 1);
        check({name, "_data"}, m_rd_data, exp);
        tick();
        check({name, "_ack_p3"}, m_rd_ack, 0);
        check({name, "_hold"}, m_rd_data, exp);
    endtask

    task automatic s_read(input string name, input logic [1:0] row, input logic [3:0] idx,
                          input logic [3:0] exp);
        s_rd_req = 1'b1;
        s_rd_row = row;
        s_rd_idx = idx;
        tick();
        s_rd_req = 1'b0;
        tick();
        check({name, "_ack"}, s_rd_ack, 1);
        check({name, "_data"}, s_rd_data, exp);
        tick();
    endtask

    task automatic apply_tok(input tok_t t);
        for (int r = 0; r < 4; r++) begin
            if (t.mask[r]) begin
                if (mdl[r][t.idx[r*4 +: 4]] == 15) msat++;
                else mdl[r][t.idx[r*4 +: 4]]++;
            end
        end
    endtask

    // One cycle of the narrow instance against the reference model; k is the cycle number.
    task automatic s_step(input int k, input logic v, input logic [15:0] idx, input logic [3:0] mask,
                          input logic rq, input logic [1:0] row, input logic [3:0] ridx);
        logic exp_ack;
        check("rand_ready", s_upd_ready, 1);
        exp_ack = (prd.size() > 0) && (prd[0].due == k);
        check("rand_ack", s_rd_ack, exp_ack);
        if (exp_ack) begin
            check("rand_data", s_rd_data, prd[0].val);
            void'(prd.pop_front());
        end
        while (ptok.size() > 0 && ptok[0].cyc <= k - 2) apply_tok(ptok.pop_front());
        if (rq) prd.push_back('{k + 2, mdl[row][ridx]});
        if (v) ptok.push_back('{k, idx, mask});
        s_upd_valid = v;
        s_upd_idx   = idx;
        s_mask      = mask;
        s_rd_req    = rq;
        s_rd_row    = row;
        s_rd_idx    = ridx;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stalls;
        int k;

        reset = 1'b1;
        m_upd_valid = 1'b0; m_upd_idx = '0; m_mask = '0; m_rd_req = 1'b0;
        m_rd_row = '0; m_rd_idx = '0; m_clear_req = 1'b0;
        s_upd_valid = 1'b0; s_upd_idx = '0; s_mask = '0; s_rd_req = 1'b0;
        s_rd_row = '0; s_rd_idx = '0; s_clear_req = 1'b0;
        idle(3);
        check("rst_ready", m_upd_ready, 0);
        check("rst_busy", m_busy, 1);
        check("rst_ack", m_rd_ack, 0);
        check("rst_data", m_rd_data, 0);
        check("rst_sat", m_sat, 0);

        reset = 1'b0;
        n = 0;
        while (n < 2000 && m_busy && !m_upd_ready) begin
            n++;
            tick();
        end
        check("release_cycles", n, 1024);
        check("release_ready", m_upd_ready, 1);
        check("release_busy", m_busy, 0);

        m_token(10'd5, 10'd6, 10'd7, 10'd8, 4'b0101);

        stalls = 0;
        m_upd_valid = 1'b1;
        m_upd_idx   = {4{10'd17}};
        m_mask      = 4'hF;
        for (int i = 0; i < 10; i++) begin
            if (!m_upd_ready) stalls++;
            tick();
        end
        m_upd_valid = 1'b0;
        check("burst_stalls", stalls, 0);
        idle(3);

        tab.push_back('{2'd2, 10'd1023, 32'd0});
        tab.push_back('{2'd0, 10'd5, 32'd1});
        tab.push_back('{2'd1, 10'd6, 32'd0});
        tab.push_back('{2'd2, 10'd7, 32'd1});
        tab.push_back('{2'd3, 10'd8, 32'd0});
        for (int r = 0; r < 4; r++) tab.push_back('{r[1:0], 10'd17, 32'd10});
        foreach (tab[i]) m_read($sformatf("tab%0d", i), tab[i].row, tab[i].idx, tab[i].exp);

        // Read lands on the same edge as the S2 write, then a re-read one cycle later.
        m_token(10'd0, 10'd0, 10'd0, 10'd100, 4'b1000);
        m_rd_req = 1'b1; m_rd_row = 2'd3; m_rd_idx = 10'd100;
        tick();
        tick();
        m_rd_req = 1'b0;
        check("coll_ack0", m_rd_ack, 1);
        check("coll_old", m_rd_data, 0);
        tick();
        check("coll_ack1", m_rd_ack, 1);
        check("coll_new", m_rd_data, 1);
        tick();
        check("coll_ack2", m_rd_ack, 0);
        check("coll_hold", m_rd_data, 1);

        m_token(10'd9, 10'd0, 10'd0, 10'd0, 4'b0001);
        m_token(10'd9, 10'd0, 10'd0, 10'd0, 4'b0001);
        m_token(10'd9, 10'd0, 10'd0, 10'd0, 4'b0001);
        idle(2);
        m_read("pre_clear", 2'd0, 10'd9, 32'd3);

        check("clr_t_ready", m_upd_ready, 1);
        m_upd_valid = 1'b1; m_upd_idx = {30'd0, 10'd9}; m_mask = 4'b0001; m_clear_req = 1'b1;
        tick();
        m_upd_valid = 1'b0; m_clear_req = 1'b0;
        check("drain_ready", m_upd_ready, 0);
        check("drain_busy", m_busy, 1);
        tick();
        m_rd_req = 1'b1; m_rd_row = 2'd0; m_rd_idx = 10'd9;
        tick();
        m_rd_req = 1'b0;
        tick();
        check("inclear_ack", m_rd_ack, 1);
        check("inclear_data", m_rd_data, 4);
        n = 4;
        while (n < 3000 && !m_upd_ready) begin
            tick();
            n++;
        end
        check("clear_ready_back", n, 1026);
        check("clear_busy", m_busy, 0);
        check("clear_sat", m_sat, 0);
        idle(1);
        m_read("post_clear9", 2'd0, 10'd9, 32'd0);
        m_read("post_clear5", 2'd0, 10'd5, 32'd0);

        s_upd_idx = 16'h0030;
        s_mask    = 4'b0010;
        for (int i = 0; i < 14; i++) begin
            check("sat_ready", s_upd_ready, 1);
            s_upd_valid = 1'b1;
            tick();
        end
        s_upd_valid = 1'b0;
        idle(2);
        s_read("pre_sat", 2'd1, 4'd3, 4'hE);
        s_upd_valid = 1'b1;
        idle(3);
        s_upd_valid = 1'b0;
        idle(2);
        check("sat_events", s_sat, 2);
        s_read("sat_val", 2'd1, 4'd3, 4'hF);

        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 16; i++) mdl[r][i] = 0;
        mdl[1][3] = 15;
        msat = 2;
        k = 0;
        for (int i = 0; i < 2000; i++) begin
            s_step(k, ($urandom % 4) != 0, 16'($urandom), 4'($urandom), 1'($urandom),
                   2'($urandom), 4'($urandom));
            k++;
        end
        for (int i = 0; i < 6; i++) begin
            s_step(k, 1'b0, '0, '0, 1'b0, '0, '0);
            k++;
        end
        check("rand_sat", s_sat, msat);
        for (int i = 0; i < 64; i++) begin
            s_step(k, 1'b0, '0, '0, 1'b1, 2'(i / 16), 4'(i % 16));
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            s_step(k, 1'b0, '0, '0, 1'b0, '0, '0);
            k++;
        end
        check("rand_drained", prd.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
